// File: rtl/csi_tx_pkg.sv
//----------------------------------------------------------------------------
// Module   : csi_tx_pkg
// Brief    : Shared types, clock patterns and default D-PHY timings for CSI-2 Tx.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package csi_tx_pkg;

  typedef enum logic [3:0] {
    ST_STOP    = 4'd0,
    ST_HS_RQST = 4'd1,
    ST_PREPARE = 4'd2,
    ST_ZERO    = 4'd3,
    ST_PRE     = 4'd4,
    ST_RUN     = 4'd5,
    ST_POST    = 4'd6,
    ST_TRAIL   = 4'd7,
    ST_EXIT    = 4'd8
  } clk_lane_state_e;

  localparam logic [7:0] CLK_PAT_TOGGLE = 8'h55;
  localparam logic [7:0] CLK_PAT_ZERO   = 8'h00;

  localparam int DPHY_T_LPX         = 4;
  localparam int DPHY_T_CLK_PREPARE = 3;
  localparam int DPHY_T_CLK_ZERO    = 20;
  localparam int DPHY_T_CLK_PRE     = 4;
  localparam int DPHY_T_CLK_POST    = 8;
  localparam int DPHY_T_CLK_TRAIL   = 4;
  localparam int DPHY_T_HS_EXIT     = 6;

  // Timing values outside 1..255 saturate so every timed state lasts at least one cycle.
  function automatic logic [7:0] clamp_timing(input int value);
    if (value < 1) begin
      return 8'd1;
    end else if (value > 255) begin
      return 8'd255;
    end else begin
      return value[7:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/csi_tx_lp_timer.sv
//----------------------------------------------------------------------------
// Module   : csi_tx_lp_timer
// Brief    : Loadable 8-bit down-counter; done marks the last cycle of a timed state.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module csi_tx_lp_timer (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done
);

  logic [7:0] r_count;

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= (load_value == 8'd0) ? 8'd1 : load_value;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Reading 1 means this is the final cycle; 0 only occurs when idle.
  assign done = (r_count <= 8'd1);

endmodule

`default_nettype wire

// File: rtl/csi_tx_clk_lane.sv
//----------------------------------------------------------------------------
// Module   : csi_tx_clk_lane
// Brief    : D-PHY clock-lane sequencer: LP-11 stop to running HS clock and back.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module csi_tx_clk_lane
  import csi_tx_pkg::*;
#(
  parameter int T_LPX         = DPHY_T_LPX,
  parameter int T_CLK_PREPARE = DPHY_T_CLK_PREPARE,
  parameter int T_CLK_ZERO    = DPHY_T_CLK_ZERO,
  parameter int T_CLK_PRE     = DPHY_T_CLK_PRE,
  parameter int T_CLK_POST    = DPHY_T_CLK_POST,
  parameter int T_CLK_TRAIL   = DPHY_T_CLK_TRAIL,
  parameter int T_HS_EXIT     = DPHY_T_HS_EXIT
) (
  input  logic       byte_clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       hs_req,
  output logic       hs_ready,
  output logic       lp_p,
  output logic       lp_n,
  output logic       hs_oe,
  output logic [7:0] clk_byte,
  output logic       stop_state
);

  localparam logic [7:0] c_t_lpx     = clamp_timing(T_LPX);
  localparam logic [7:0] c_t_prepare = clamp_timing(T_CLK_PREPARE);
  localparam logic [7:0] c_t_zero    = clamp_timing(T_CLK_ZERO);
  localparam logic [7:0] c_t_pre     = clamp_timing(T_CLK_PRE);
  localparam logic [7:0] c_t_post    = clamp_timing(T_CLK_POST);
  localparam logic [7:0] c_t_trail   = clamp_timing(T_CLK_TRAIL);
  localparam logic [7:0] c_t_exit    = clamp_timing(T_HS_EXIT);

  clk_lane_state_e r_state;
  clk_lane_state_e w_state_next;
  logic            w_load;
  logic [7:0]      w_load_value;
  logic            w_timer_done;

  logic            r_hs_ready;
  logic            r_lp_p;
  logic            r_lp_n;
  logic            r_hs_oe;
  logic [7:0]      r_clk_byte;
  logic            r_stop_state;

  logic            w_hs_ready;
  logic            w_lp_p;
  logic            w_lp_n;
  logic            w_hs_oe;
  logic [7:0]      w_clk_byte;
  logic            w_stop_state;

  csi_tx_lp_timer u_timer (
    .byte_clock (byte_clock),
    .reset_n    (reset_n),
    .load       (w_load),
    .load_value (w_load_value),
    .done       (w_timer_done)
  );

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The timer is reloaded on the same edge that enters each timed state.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_value = c_t_lpx;
    case (r_state)
      ST_STOP: begin
        if (hs_req && enable) begin
          w_state_next = ST_HS_RQST;
          w_load       = 1'b1;
          w_load_value = c_t_lpx;
        end
      end
      ST_HS_RQST: begin
        if (w_timer_done) begin
          w_state_next = ST_PREPARE;
          w_load       = 1'b1;
          w_load_value = c_t_prepare;
        end
      end
      ST_PREPARE: begin
        if (w_timer_done) begin
          w_state_next = ST_ZERO;
          w_load       = 1'b1;
          w_load_value = c_t_zero;
        end
      end
      ST_ZERO: begin
        if (w_timer_done) begin
          w_state_next = ST_PRE;
          w_load       = 1'b1;
          w_load_value = c_t_pre;
        end
      end
      ST_PRE: begin
        if (w_timer_done) begin
          if (hs_req) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_POST;
            w_load       = 1'b1;
            w_load_value = c_t_post;
          end
        end
      end
      ST_RUN: begin
        if (!hs_req) begin
          w_state_next = ST_POST;
          w_load       = 1'b1;
          w_load_value = c_t_post;
        end
      end
      ST_POST: begin
        if (w_timer_done) begin
          w_state_next = ST_TRAIL;
          w_load       = 1'b1;
          w_load_value = c_t_trail;
        end
      end
      ST_TRAIL: begin
        if (w_timer_done) begin
          w_state_next = ST_EXIT;
          w_load       = 1'b1;
          w_load_value = c_t_exit;
        end
      end
      ST_EXIT: begin
        if (w_timer_done) begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_EXIT;
        w_load       = 1'b1;
        w_load_value = c_t_exit;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    w_lp_p       = 1'b0;
    w_lp_n       = 1'b0;
    w_hs_oe      = 1'b0;
    w_clk_byte   = CLK_PAT_ZERO;
    w_hs_ready   = 1'b0;
    w_stop_state = 1'b0;
    case (w_state_next)
      ST_STOP: begin
        w_lp_p       = 1'b1;
        w_lp_n       = 1'b1;
        w_stop_state = 1'b1;
      end
      ST_HS_RQST: begin
        w_lp_n = 1'b1;
      end
      ST_PREPARE: begin
        w_hs_oe = 1'b0;
      end
      ST_ZERO, ST_TRAIL: begin
        w_hs_oe = 1'b1;
      end
      ST_PRE, ST_POST: begin
        w_hs_oe    = 1'b1;
        w_clk_byte = CLK_PAT_TOGGLE;
      end
      ST_RUN: begin
        w_hs_oe    = 1'b1;
        w_clk_byte = CLK_PAT_TOGGLE;
        w_hs_ready = 1'b1;
      end
      default: begin
        w_lp_p = 1'b1;
        w_lp_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lp_p       <= 1'b1;
      r_lp_n       <= 1'b1;
      r_hs_oe      <= 1'b0;
      r_clk_byte   <= CLK_PAT_ZERO;
      r_hs_ready   <= 1'b0;
      r_stop_state <= 1'b1;
    end else begin
      r_lp_p       <= w_lp_p;
      r_lp_n       <= w_lp_n;
      r_hs_oe      <= w_hs_oe;
      r_clk_byte   <= w_clk_byte;
      r_hs_ready   <= w_hs_ready;
      r_stop_state <= w_stop_state;
    end
  end

  assign lp_p       = r_lp_p;
  assign lp_n       = r_lp_n;
  assign hs_oe      = r_hs_oe;
  assign clk_byte   = r_clk_byte;
  assign hs_ready   = r_hs_ready;
  assign stop_state = r_stop_state;

endmodule

`default_nettype wire

// File: tb/tb_csi_tx_clk_lane.sv
//----------------------------------------------------------------------------
// Module   : tb_csi_tx_clk_lane
// Brief    : Self-checking bench for csi_tx_clk_lane against a segment-queue model.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_csi_tx_clk_lane;

  // Observed tuple: {lp_p, lp_n, hs_oe, hs_ready, stop_state, clk_byte}
  localparam logic [12:0] O_STOP = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
  localparam logic [12:0] O_RQST = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_PREP = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_HS0  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_TOG  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
  localparam logic [12:0] O_RUN  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
  localparam logic [12:0] O_EXIT = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_EXITING = 3;

  logic       byte_clock = 1'b0;
  logic       reset_n    = 1'b1;
  logic       enable0, hs_req0, enable1, hs_req1;
  logic       hs_ready0, lp_p0, lp_n0, hs_oe0, stop_state0;
  logic       hs_ready1, lp_p1, lp_n1, hs_oe1, stop_state1;
  logic [7:0] clk_byte0, clk_byte1;
  logic [12:0] obs0, obs1;

  int checks = 0;
  int fails  = 0;

  always #5 byte_clock = ~byte_clock;

  csi_tx_clk_lane dut0 (
    .byte_clock (byte_clock), .reset_n (reset_n), .enable (enable0), .hs_req (hs_req0),
    .hs_ready (hs_ready0), .lp_p (lp_p0), .lp_n (lp_n0), .hs_oe (hs_oe0),
    .clk_byte (clk_byte0), .stop_state (stop_state0)
  );

  csi_tx_clk_lane #(
    .T_LPX (0), .T_CLK_PREPARE (0), .T_CLK_ZERO (0), .T_CLK_PRE (0),
    .T_CLK_POST (0), .T_CLK_TRAIL (0), .T_HS_EXIT (0)
  ) dut1 (
    .byte_clock (byte_clock), .reset_n (reset_n), .enable (enable1), .hs_req (hs_req1),
    .hs_ready (hs_ready1), .lp_p (lp_p1), .lp_n (lp_n1), .hs_oe (hs_oe1),
    .clk_byte (clk_byte1), .stop_state (stop_state1)
  );

  assign obs0 = {lp_p0, lp_n0, hs_oe0, hs_ready0, stop_state0, clk_byte0};
  assign obs1 = {lp_p1, lp_n1, hs_oe1, hs_ready1, stop_state1, clk_byte1};

  // Reference model: each request expands into a queue of per-cycle output tuples,
  // with decisions taken only where the lane behaviour depends on hs_req.
  int          dur   [2][7];
  logic [12:0] mq    [2][$];
  int          mmode [2];
  logic [12:0] mexp  [2];

  task automatic push_n(input int k, input logic [12:0] item, input int n);
    for (int i = 0; i < n; i++) mq[k].push_back(item);
  endtask

  task automatic model_step(input int k, input logic h, input logic en);
    if (mq[k].size() > 0) begin
      mexp[k] = mq[k].pop_front();
    end else if (mmode[k] == M_IDLE) begin
      if (h && en) begin
        push_n(k, O_RQST, dur[k][0]);
        push_n(k, O_PREP, dur[k][1]);
        push_n(k, O_HS0,  dur[k][2]);
        push_n(k, O_TOG,  dur[k][3]);
        mexp[k]  = mq[k].pop_front();
        mmode[k] = M_ENTRY;
      end else begin
        mexp[k] = O_STOP;
      end
    end else if (mmode[k] == M_ENTRY || mmode[k] == M_RUN) begin
      if (h) begin
        mexp[k]  = O_RUN;
        mmode[k] = M_RUN;
      end else begin
        push_n(k, O_TOG,  dur[k][4]);
        push_n(k, O_HS0,  dur[k][5]);
        push_n(k, O_EXIT, dur[k][6]);
        mexp[k]  = mq[k].pop_front();
        mmode[k] = M_EXITING;
      end
    end else begin
      mexp[k]  = O_STOP;
      mmode[k] = M_IDLE;
    end
  endtask

  always @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        mmode[k] = M_IDLE;
        mexp[k]  = O_STOP;
      end
    end else begin
      model_step(0, hs_req0, enable0);
      model_step(1, hs_req1, enable1);
    end
  end

  function automatic int entry_latency(input int k);
    return 1 + dur[k][0] + dur[k][1] + dur[k][2] + dur[k][3];
  endfunction

  function automatic int exit_latency(input int k);
    return 1 + dur[k][4] + dur[k][5] + dur[k][6];
  endfunction

  task automatic test_reset();
    hs_req0 = 1'b0; enable0 = 1'b1;
    hs_req1 = 1'b0; enable1 = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (obs0 !== O_STOP) begin
      fails++; $display("FAIL reset_state0: observed %h expected %h", obs0, O_STOP);
    end
    checks++;
    if (obs1 !== O_STOP) begin
      fails++; $display("FAIL reset_state1: observed %h expected %h", obs1, O_STOP);
    end
    repeat (3) @(negedge byte_clock);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge byte_clock);
      checks++;
      if (obs0 !== O_STOP || obs0 !== mexp[0]) begin
        fails++; $display("FAIL idle_stop: cycle %0d observed %h expected %h", i, obs0, O_STOP);
      end
    end
  endtask

  task automatic test_full_cycle();
    int n;
    logic got;
    hs_req0 = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL full_entry: cycle %0d observed %h expected %h", n, obs0, mexp[0]);
      end
      if (hs_ready0) got = 1'b1;
    end
    checks++;
    if (n != entry_latency(0)) begin
      fails++; $display("FAIL entry_latency: observed %0d expected %0d", n, entry_latency(0));
    end
    for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
      @(negedge byte_clock);
      checks++;
      if (obs0 !== O_RUN) begin
        fails++; $display("FAIL run_hold: observed %h expected %h", obs0, O_RUN);
      end
    end
    hs_req0 = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL full_exit: cycle %0d observed %h expected %h", n, obs0, mexp[0]);
      end
      if (stop_state0) got = 1'b1;
    end
    checks++;
    if (n != exit_latency(0)) begin
      fails++; $display("FAIL exit_latency: observed %0d expected %0d", n, exit_latency(0));
    end
  endtask

  task automatic test_abort();
    int n;
    logic got, saw_ready;
    hs_req0 = 1'b1;
    n = 0; got = 1'b0; saw_ready = 1'b0;
    while (!got && n < 200) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL abort_seq: cycle %0d observed %h expected %h", n, obs0, mexp[0]);
      end
      if (hs_ready0) saw_ready = 1'b1;
      if (stop_state0) got = 1'b1;
      if (n == 2) hs_req0 = 1'b0;
    end
    checks++;
    if (n != entry_latency(0) - 1 + exit_latency(0)) begin
      fails++; $display("FAIL abort_latency: observed %0d expected %0d", n,
                        entry_latency(0) - 1 + exit_latency(0));
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      fails++; $display("FAIL abort_no_ready: observed %b expected 0", saw_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, exit_cnt, stop_cnt;
    logic got;
    hs_req0 = 1'b1;
    n = 0;
    while (!hs_ready0 && n < 200) begin
      @(negedge byte_clock);
      n++;
    end
    hs_req0 = 1'b0;
    n = 0; exit_cnt = 0; stop_cnt = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL b2b_seq: cycle %0d observed %h expected %h", n, obs0, mexp[0]);
      end
      if (obs0 === O_EXIT) exit_cnt++;
      if (obs0 === O_STOP && exit_cnt > 0) stop_cnt++;
      if (obs0 === O_RQST && stop_cnt > 0) got = 1'b1;
      if (exit_cnt == 2) hs_req0 = 1'b1;
    end
    checks++;
    if (exit_cnt != dur[0][6] || stop_cnt != 1 || !got) begin
      fails++; $display("FAIL b2b_timing: exit %0d stop %0d rqst %b expected exit %0d stop 1 rqst 1",
                        exit_cnt, stop_cnt, got, dur[0][6]);
    end
    hs_req0 = 1'b0;
    n = 0;
    while (!stop_state0 && n < 200) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL b2b_drain: cycle %0d observed %h expected %h", n, obs0, mexp[0]);
      end
    end
    checks++;
    if (stop_state0 !== 1'b1) begin
      fails++; $display("FAIL b2b_timeout: observed %b expected 1", stop_state0);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    hs_req0 = 1'b1;
    n = 0;
    while (!hs_ready0 && n < 200) begin
      @(negedge byte_clock);
      n++;
    end
    checks++;
    if (obs0 !== O_RUN) begin
      fails++; $display("FAIL pre_reset_run: observed %h expected %h", obs0, O_RUN);
    end
    @(posedge byte_clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== O_STOP) begin
      fails++; $display("FAIL reset_mid_run: observed %h expected %h", obs0, O_STOP);
    end
    @(negedge byte_clock);
    hs_req0 = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge byte_clock);
      checks++;
      if (obs0 !== O_STOP || obs0 !== mexp[0]) begin
        fails++; $display("FAIL post_reset_stop: observed %h expected %h", obs0, O_STOP);
      end
    end
  endtask

  task automatic test_param_edge();
    int n;
    enable1 = 1'b0;
    hs_req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge byte_clock);
      checks++;
      if (obs1 !== O_STOP || obs1 !== mexp[1]) begin
        fails++; $display("FAIL enable_block: observed %h expected %h", obs1, O_STOP);
      end
    end
    enable1 = 1'b1;
    n = 0;
    while (!hs_ready1 && n < 100) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs1 !== mexp[1]) begin
        fails++; $display("FAIL min_entry: cycle %0d observed %h expected %h", n, obs1, mexp[1]);
      end
    end
    checks++;
    if (n != entry_latency(1)) begin
      fails++; $display("FAIL min_entry_latency: observed %0d expected %0d", n, entry_latency(1));
    end
    hs_req1 = 1'b0;
    n = 0;
    while (!stop_state1 && n < 100) begin
      @(negedge byte_clock);
      n++;
      checks++;
      if (obs1 !== mexp[1]) begin
        fails++; $display("FAIL min_exit: cycle %0d observed %h expected %h", n, obs1, mexp[1]);
      end
    end
    checks++;
    if (n != exit_latency(1)) begin
      fails++; $display("FAIL min_exit_latency: observed %0d expected %0d", n, exit_latency(1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge byte_clock);
      checks++;
      if (obs0 !== mexp[0]) begin
        fails++; $display("FAIL random0: cycle %0d observed %h expected %h", i, obs0, mexp[0]);
      end
      checks++;
      if (obs1 !== mexp[1]) begin
        fails++; $display("FAIL random1: cycle %0d observed %h expected %h", i, obs1, mexp[1]);
      end
      if ($urandom_range(0, 23) == 0) hs_req0 = ~hs_req0;
      if ($urandom_range(0, 3) == 0) hs_req1 = ~hs_req1;
      enable0 = ($urandom_range(0, 7) != 0);
      enable1 = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mmode[k] = M_IDLE;
      mexp[k]  = O_STOP;
    end
    dur[0] = '{4, 3, 20, 4, 8, 4, 6};
    // Second instance is built with every timing at 0, which must behave as 1.
    dur[1] = '{1, 1, 1, 1, 1, 1, 1};
    test_reset();
    test_full_cycle();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    test_param_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed time %0t expected completion", $time);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

`default_nettype wire
